// File: rtl/tiger_regfile.sv
// Register file: 32 GPRs plus a coprocessor bank, two GPR read ports and one
// COP read port (all registered), zeroed by a post-reset sweep. Optional
// write-first bypass is enabled by defining TIGER_REGFILE_BYPASS_EN.
module tiger_regfile #(
  parameter int          NUM_COP_REGS = 32,
  parameter logic [31:0] RESET_DATA   = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        writeRegEn,
  input  logic        writeRegEnCop,
  input  logic [4:0]  writeRegNum,
  input  logic [31:0] writeRegData,
  input  logic [4:0]  readRegNumA,
  input  logic [4:0]  readRegNumB,
  input  logic [4:0]  readCopNum,
  output logic [31:0] readDataA,
  output logic [31:0] readDataB,
  output logic [31:0] readCopData,
  output logic        busy
);

  localparam int CW = $clog2(NUM_COP_REGS);

  typedef enum logic {
    CLEAR = 1'b0,
    RUN   = 1'b1
  } state_t;

  state_t      r_state;
  state_t      w_state_nxt;
  logic [4:0]  r_cnt;

  logic [31:0] r_gpr [32];
  logic [31:0] r_cop [NUM_COP_REGS];

  logic          w_run;
  logic          w_gpr_we;
  logic          w_cop_we;
  logic [CW-1:0] w_cop_waddr;
  logic [CW-1:0] w_cop_raddr;
  logic [CW-1:0] w_cnt_cop;
  logic          w_cnt_in_cop;
  logic [31:0]   w_rd_a;
  logic [31:0]   w_rd_b;
  logic [31:0]   w_rd_cop;

  assign busy         = (r_state == CLEAR);
  assign w_run        = (r_state == RUN) && !reset;
  assign w_gpr_we     = w_run && writeRegEn && (writeRegNum != 5'd0);
  assign w_cop_we     = w_run && writeRegEnCop;
  assign w_cop_waddr  = writeRegNum[CW-1:0];
  assign w_cop_raddr  = readCopNum[CW-1:0];
  assign w_cnt_cop    = r_cnt[CW-1:0];
  assign w_cnt_in_cop = (32'(r_cnt) < NUM_COP_REGS);

  // Sweep FSM: CLEAR walks r_cnt through all 32 entries, then hands over to RUN.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      CLEAR:   if (r_cnt == 5'd31) w_state_nxt = RUN;
      RUN:     w_state_nxt = RUN;
      default: w_state_nxt = CLEAR;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= CLEAR;
      r_cnt   <= 5'd0;
    end else begin
      r_state <= w_state_nxt;
      if (r_state == CLEAR) r_cnt <= r_cnt + 5'd1;
    end
  end

  // Storage has no reset of its own; the sweep is what initialises it.
  always_ff @(posedge clk) begin
    if (!reset && (r_state == CLEAR)) begin
      r_gpr[r_cnt] <= RESET_DATA;
      if (w_cnt_in_cop) r_cop[w_cnt_cop] <= RESET_DATA;
    end else begin
      if (w_gpr_we) r_gpr[writeRegNum] <= writeRegData;
      if (w_cop_we) r_cop[w_cop_waddr] <= writeRegData;
    end
  end

  always_comb begin
    w_rd_a   = (readRegNumA == 5'd0) ? 32'd0 : r_gpr[readRegNumA];
    w_rd_b   = (readRegNumB == 5'd0) ? 32'd0 : r_gpr[readRegNumB];
    w_rd_cop = r_cop[w_cop_raddr];
`ifdef TIGER_REGFILE_BYPASS_EN
    // Write-first: w_gpr_we already excludes r0 and CLEAR, so no extra guard.
    if (w_gpr_we && (writeRegNum == readRegNumA)) w_rd_a = writeRegData;
    if (w_gpr_we && (writeRegNum == readRegNumB)) w_rd_b = writeRegData;
    if (w_cop_we && (w_cop_waddr == w_cop_raddr)) w_rd_cop = writeRegData;
`endif
  end

  always_ff @(posedge clk) begin
    if (reset || (r_state == CLEAR)) begin
      readDataA   <= 32'd0;
      readDataB   <= 32'd0;
      readCopData <= 32'd0;
    end else begin
      readDataA   <= w_rd_a;
      readDataB   <= w_rd_b;
      readCopData <= w_rd_cop;
    end
  end

endmodule

// File: doc/tiger_regfile.md
Name: tiger_regfile

Overview:
- Register-file end of the writeback interface. Holds the 32 general-purpose registers and a coprocessor register bank.
- Accepts the write port driven by the writeback stage (writeRegEn, writeRegEnCop, writeRegNum, writeRegData).
- Serves two synchronous GPR read ports and one coprocessor read port to decode.
- After reset, a sweep state machine zeroes every entry; busy stalls the pipeline until the sweep finishes.

Parameters:
- NUM_COP_REGS, 32, number of coprocessor registers. Must be a power of two, 2..32; the index uses the low log2(NUM_COP_REGS) bits of the register number.
- RESET_DATA, 32'h0000_0000, value written into every entry during the sweep.

Ports:
- clk  input  1  system clock, all logic on rising edge
- reset  input  1  synchronous, active-high
- writeRegEn  input  1  write GPR bank
- writeRegEnCop  input  1  write coprocessor bank
- writeRegNum  input  5  destination register number
- writeRegData  input  32  write data
- readRegNumA  input  5  GPR read address A
- readRegNumB  input  5  GPR read address B
- readCopNum  input  5  coprocessor read address
- readDataA  output  32  GPR data for A, registered
- readDataB  output  32  GPR data for B, registered
- readCopData  output  32  coprocessor data, registered
- busy  output  1  high while the clear sweep runs

Behaviour:
- Clock and reset: one clock, clk. Reset is synchronous and active-high; all state changes on the rising edge of clk.
- States: CLEAR, RUN.
- Reset (sampled high at an edge): state=CLEAR, sweep counter=0, busy=1, readDataA/B and readCopData=0.
  - Reset during CLEAR restarts the counter at 0.
  - Reset during RUN re-enters CLEAR.
- CLEAR, each cycle: write RESET_DATA to GPR[cnt], and to COP[cnt] when cnt<NUM_COP_REGS; then cnt++.
  - At cnt=31 the sweep writes its last entry and the next state is RUN.
  - busy is high for exactly 32 cycles after reset deasserts.
  - External writes are dropped during CLEAR.
  - Read outputs are held at 0 during CLEAR.
- RUN: busy=0.
  - writeRegEn=1 with writeRegNum≠0: GPR[writeRegNum]<=writeRegData.
  - writeRegEnCop=1: COP[writeRegNum[log2(NUM_COP_REGS)-1:0]]<=writeRegData. Coprocessor register 0 is writable.
  - Both enables high in one cycle: both banks are written with the same data.
- Register 0: writes to GPR 0 are ignored, and a read of GPR 0 always returns 0, including under bypass.
- Read latency: 1 cycle. Addresses are sampled at edge N; data appears after edge N and is stable for all of cycle N+1. Outputs update every cycle; there is no read enable.
- Same-address reads: A and B may address the same register; both return identical data.
- Same-cycle read and write to the same address: governed by the optional feature below.
- Write-address aliasing in COP: upper writeRegNum bits are discarded. Writes through aliased numbers hit the same entry.
- Out-of-range COP read addresses alias the same way.

Optional Feature:
- Macro: TIGER_REGFILE_BYPASS_EN.
- Defined: write-first. A read at edge N of a register being written at edge N returns writeRegData.
  - GPR: applies when writeRegEn=1 and the address is nonzero.
  - COP: applies when writeRegEnCop=1 and the masked addresses match.
  - Removes the one-cycle writeback-to-decode hazard.
- Undefined: read-first. The read returns the value held before the write; the new value is visible from the next read.
- The bypass never applies during CLEAR.

Test Plan:
- Reset for 1 cycle, then release → busy=1 for exactly 32 cycles, then 0. A read of r5 and COP r12 returns 0.
- RUN: write r7=0xDEADBEEF, then read A=7, B=7 the next cycle → both readDataA and readDataB =0xDEADBEEF one cycle after the read.
- writeRegEn=1, writeRegNum=0, data 0x12345678; then read A=0 → readDataA=0.
- Same cycle: write r3=0xA5A5A5A5 and read A=3 (previous r3=0x1) → 0xA5A5A5A5 with TIGER_REGFILE_BYPASS_EN defined, 0x00000001 without it. The following read returns 0xA5A5A5A5 in both builds.
- Both enables high, writeRegNum=12, data 0x0BADF00D; then read A=12 and readCopNum=12 → both return 0x0BADF00D.
- Assert reset again at sweep count 10 after a prior r9=0x55 write → busy stays high a full 32 cycles from the new release. A write of r9=0x77 during CLEAR is dropped; r9 reads 0 in RUN.
